// File: rtl/affinex_pkg.sv
`default_nettype none
// ============================================================================
// affinex_pkg : register map, bus size codes and master FSM states  (rev 1.0)
// ============================================================================
package affinex_pkg;

  localparam logic [5:0] ADDR_CONTROL     = 6'h00;
  localparam logic [5:0] ADDR_STATUS      = 6'h04;
  localparam logic [5:0] ADDR_A           = 6'h08;
  localparam logic [5:0] ADDR_B           = 6'h0C;
  localparam logic [5:0] ADDR_D           = 6'h10;
  localparam logic [5:0] ADDR_E           = 6'h14;
  localparam logic [5:0] ADDR_TX          = 6'h18;
  localparam logic [5:0] ADDR_TY          = 6'h1C;
  localparam logic [5:0] ADDR_XIN         = 6'h20;
  localparam logic [5:0] ADDR_YIN         = 6'h24;
  localparam logic [5:0] ADDR_XOUT        = 6'h28;
  localparam logic [5:0] ADDR_YOUT        = 6'h2C;
  localparam logic [5:0] ADDR_FIFO_CTRL   = 6'h30;
  localparam logic [5:0] ADDR_FIFO_STATUS = 6'h34;
  localparam logic [5:0] ADDR_FIFO_XOUT   = 6'h38;
  localparam logic [5:0] ADDR_FIFO_YOUT   = 6'h3C;

  localparam logic [1:0] SZ_NONE = 2'b11;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [3:0] {
    IDLE,
    CFG_WR,
    PT_WR_X,
    PT_WR_Y,
    CTRL_SET,
    WAIT,
    CTRL_CLR,
    POLL,
    RD_X,
    RD_Y,
    OUT
  } state_t;

endpackage
`default_nettype wire

// File: rtl/affinex_bus_txn.sv
`default_nettype none
// ============================================================================
// affinex_bus_txn : single 32-bit register write/read with trailing gap cycle
// Revision 1.0
// ============================================================================
module affinex_bus_txn
  import affinex_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        is_wr,
  input  logic [5:0]  addr,
  input  logic [15:0] wdata,
  output logic        done,
  output logic [15:0] rdata,
  output logic [5:0]  address,
  output logic [31:0] data_out,
  output logic [1:0]  data_write_n,
  output logic [1:0]  data_read_n,
  input  logic [31:0] data_in,
  input  logic        data_ready
);

  logic gap;
  logic unused_data_hi;

  assign unused_data_hi = ^data_in[31:16];
  assign done           = gap;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gap   <= 1'b0;
      rdata <= 16'h0000;
    end else if (gap) begin
      gap <= 1'b0;
    end else if (req && (is_wr || data_ready)) begin
      gap <= 1'b1;
      if (!is_wr) begin
        rdata <= data_in[15:0];
      end
    end
  end

  // Bus is driven only from registered state, never combinationally from data_ready
  always_comb begin
    address      = 6'h00;
    data_out     = 32'h0000_0000;
    data_write_n = SZ_NONE;
    data_read_n  = SZ_NONE;
    if (req && !gap) begin
      address = addr;
      if (is_wr) begin
        data_write_n = SZ_WORD;
        data_out     = {{16{wdata[15]}}, wdata};
      end else begin
        data_read_n = SZ_WORD;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/affinex_bus_master.sv
`default_nettype none
// ============================================================================
// affinex_bus_master : streams coefficient sets and points through the affine
// peripheral's register interface and returns transformed points.  (rev 1.0)
// ============================================================================
module affinex_bus_master
  import affinex_pkg::*;
#(
  parameter int WAIT_CYCLES = 40,
  parameter int MAX_POLLS   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [15:0] cfg_a,
  input  logic [15:0] cfg_b,
  input  logic [15:0] cfg_d,
  input  logic [15:0] cfg_e,
  input  logic [15:0] cfg_tx,
  input  logic [15:0] cfg_ty,
  input  logic        pt_valid,
  output logic        pt_ready,
  input  logic [15:0] pt_x,
  input  logic [15:0] pt_y,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_x,
  output logic [15:0] res_y,
  output logic        err_timeout,
  output logic [5:0]  address,
  output logic [31:0] data_out,
  output logic [1:0]  data_write_n,
  output logic [1:0]  data_read_n,
  input  logic [31:0] data_in,
  input  logic        data_ready
);

  localparam logic [15:0] WAIT_LAST = 16'(WAIT_CYCLES - 1);
  localparam logic [15:0] POLL_LAST = 16'(MAX_POLLS - 1);

  state_t      state, next_state;
  logic [15:0] coef_a, coef_b, coef_d, coef_e, coef_tx, coef_ty;
  logic [15:0] pnt_x, pnt_y;
  logic [2:0]  cfg_idx;
  logic        cfg_loaded;
  logic [15:0] wait_cnt, poll_cnt;
  logic        req, is_wr, done;
  logic [5:0]  addr;
  logic [15:0] wdata, rdata;

  assign cfg_ready = rst_n && (state == IDLE);
  assign pt_ready  = rst_n && (state == IDLE) && cfg_loaded && !cfg_valid;
  assign res_valid = (state == OUT);

  affinex_bus_txn u_txn (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .is_wr        (is_wr),
    .addr         (addr),
    .wdata        (wdata),
    .done         (done),
    .rdata        (rdata),
    .address      (address),
    .data_out     (data_out),
    .data_write_n (data_write_n),
    .data_read_n  (data_read_n),
    .data_in      (data_in),
    .data_ready   (data_ready)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cfg_loaded  <= 1'b0;
      err_timeout <= 1'b0;
      cfg_idx     <= 3'd0;
      wait_cnt    <= 16'd0;
      poll_cnt    <= 16'd0;
      res_x       <= 16'h0000;
      res_y       <= 16'h0000;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          cfg_idx  <= 3'd0;
          wait_cnt <= 16'd0;
          poll_cnt <= 16'd0;
          if (cfg_valid) begin
            coef_a  <= cfg_a;
            coef_b  <= cfg_b;
            coef_d  <= cfg_d;
            coef_e  <= cfg_e;
            coef_tx <= cfg_tx;
            coef_ty <= cfg_ty;
          end else if (pt_valid && cfg_loaded) begin
            pnt_x <= pt_x;
            pnt_y <= pt_y;
          end
        end
        CFG_WR: if (done) begin
          cfg_idx <= cfg_idx + 3'd1;
          if (cfg_idx == 3'd5) cfg_loaded <= 1'b1;
        end
        WAIT: wait_cnt <= wait_cnt + 16'd1;
        POLL: if (done && !rdata[0]) begin
          poll_cnt <= poll_cnt + 16'd1;
          if (poll_cnt == POLL_LAST) err_timeout <= 1'b1;
        end
        RD_X: if (done) res_x <= rdata;
        RD_Y: if (done) res_y <= rdata;
        default: ;
      endcase
    end
  end

  always_comb begin
    next_state = state;
    req        = 1'b0;
    is_wr      = 1'b0;
    addr       = ADDR_CONTROL;
    wdata      = 16'h0000;
    case (state)
      IDLE: begin
        if (cfg_valid)                    next_state = CFG_WR;
        else if (pt_valid && cfg_loaded)  next_state = PT_WR_X;
      end
      CFG_WR: begin
        req   = 1'b1;
        is_wr = 1'b1;
        case (cfg_idx)
          3'd0:    begin addr = ADDR_A;  wdata = coef_a;  end
          3'd1:    begin addr = ADDR_B;  wdata = coef_b;  end
          3'd2:    begin addr = ADDR_D;  wdata = coef_d;  end
          3'd3:    begin addr = ADDR_E;  wdata = coef_e;  end
          3'd4:    begin addr = ADDR_TX; wdata = coef_tx; end
          default: begin addr = ADDR_TY; wdata = coef_ty; end
        endcase
        if (done && cfg_idx == 3'd5) next_state = IDLE;
      end
      PT_WR_X: begin
        req = 1'b1; is_wr = 1'b1; addr = ADDR_XIN; wdata = pnt_x;
        if (done) next_state = PT_WR_Y;
      end
      PT_WR_Y: begin
        req = 1'b1; is_wr = 1'b1; addr = ADDR_YIN; wdata = pnt_y;
        if (done) next_state = CTRL_SET;
      end
      CTRL_SET: begin
        req = 1'b1; is_wr = 1'b1; addr = ADDR_CONTROL; wdata = 16'h0001;
        if (done) next_state = WAIT;
      end
      WAIT: begin
        if (wait_cnt == WAIT_LAST) next_state = CTRL_CLR;
      end
      CTRL_CLR: begin
        // Clearing CONTROL stops the peripheral from free-running on stale inputs
        req = 1'b1; is_wr = 1'b1; addr = ADDR_CONTROL; wdata = 16'h0000;
        if (done) next_state = POLL;
      end
      POLL: begin
        req = 1'b1; addr = ADDR_STATUS;
        if (done) begin
          if (rdata[0])                   next_state = RD_X;
          else if (poll_cnt == POLL_LAST) next_state = IDLE;
        end
      end
      RD_X: begin
        req = 1'b1; addr = ADDR_XOUT;
        if (done) next_state = RD_Y;
      end
      RD_Y: begin
        req = 1'b1; addr = ADDR_YOUT;
        if (done) next_state = OUT;
      end
      OUT: begin
        if (res_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_affinex_bus_master.sv
`default_nettype none
// ============================================================================
// tb_affinex_bus_master : peripheral model + result scoreboard for the master
// Revision 1.0
// ============================================================================
module tb_affinex_bus_master;

  localparam int W  = 40;
  localparam int MP = 16;

  logic        clk, rst_n;
  logic        cfg_valid, cfg_ready;
  logic [15:0] cfg_a, cfg_b, cfg_d, cfg_e, cfg_tx, cfg_ty;
  logic        pt_valid, pt_ready;
  logic [15:0] pt_x, pt_y;
  logic        res_valid, res_ready;
  logic [15:0] res_x, res_y;
  logic        err_timeout;
  logic [5:0]  address;
  logic [31:0] data_out;
  logic [1:0]  data_write_n, data_read_n;
  logic [31:0] data_in;
  logic        data_ready;

  affinex_bus_master #(.WAIT_CYCLES(W), .MAX_POLLS(MP)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_a(cfg_a), .cfg_b(cfg_b), .cfg_d(cfg_d), .cfg_e(cfg_e),
    .cfg_tx(cfg_tx), .cfg_ty(cfg_ty),
    .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_x(pt_x), .pt_y(pt_y),
    .res_valid(res_valid), .res_ready(res_ready), .res_x(res_x), .res_y(res_y),
    .err_timeout(err_timeout),
    .address(address), .data_out(data_out),
    .data_write_n(data_write_n), .data_read_n(data_read_n),
    .data_in(data_in), .data_ready(data_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] affine(input logic [15:0] c0, c1, v0, v1, off);
    int p;
    p = int'($signed(c0)) * int'($signed(v0)) + int'($signed(c1)) * int'($signed(v1));
    return 16'((p >>> 8) + int'($signed(off)));
  endfunction

  function automatic logic [39:0] wr_ent(input logic [5:0] a, input logic [31:0] d);
    return {2'b00, a, d};
  endfunction

  function automatic logic [39:0] rd_ent(input logic [5:0] a);
    return {2'b10, a, 32'h0};
  endfunction

  // ---------------- behavioural peripheral ----------------
  logic [15:0] m_reg [16];
  logic [39:0] bus_log[$];
  logic [39:0] exp_log[$];
  int  stall_left = 0, xout_run = 0, xout_run_last = 0, status_reads = 0, gap_viol = 0;
  bit  status_sticky = 0, status_force0 = 0, prev_done = 0;

  always @(negedge clk) begin : periph
    logic act;
    data_ready = 1'b1;
    data_in    = 32'hDEAD_0000;
    act = (data_write_n != 2'b11) || (data_read_n != 2'b11);
    if (!rst_n) begin
      prev_done = 0;
      xout_run  = 0;
    end else begin
      if (prev_done && act) gap_viol++;
      prev_done = 0;
      if (data_write_n == 2'b10) begin
        bus_log.push_back(wr_ent(address, data_out));
        m_reg[address[5:2]] = data_out[15:0];
        if (address == 6'h00 && data_out[0]) begin
          m_reg[10] = affine(m_reg[2], m_reg[3], m_reg[8], m_reg[9], m_reg[6]);
          m_reg[11] = affine(m_reg[4], m_reg[5], m_reg[8], m_reg[9], m_reg[7]);
          status_sticky = 1;
        end
        prev_done = 1;
      end else if (data_read_n == 2'b10) begin
        if (address == 6'h28) xout_run++;
        if (address == 6'h28 && stall_left > 0) begin
          data_ready = 1'b0;
          stall_left--;
        end else begin
          if (address == 6'h04) begin
            status_reads++;
            data_in[15:0] = {15'b0, status_sticky && !status_force0};
          end else begin
            data_in[15:0] = m_reg[address[5:2]];
          end
          if (address == 6'h28) begin
            xout_run_last = xout_run;
            xout_run      = 0;
          end
          bus_log.push_back(rd_ent(address));
          prev_done = 1;
        end
      end
    end
  end

  // ---------------- result scoreboard ----------------
  logic [31:0] exp_q[$];

  always @(negedge clk) begin : monitor
    logic [31:0] e;
    if (rst_n && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        check_value("res_unexpected", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check_value("res_x", res_x, e[31:16]);
        check_value("res_y", res_y, e[15:0]);
      end
    end
  end

  logic [15:0] k_a, k_b, k_d, k_e, k_tx, k_ty;

  task automatic compare_log(input string tag);
    check_value({tag, "_len"}, bus_log.size(), exp_log.size());
    for (int i = 0; i < exp_log.size() && i < bus_log.size(); i++)
      check_value(tag, bus_log[i], exp_log[i]);
    bus_log.delete();
    exp_log.delete();
  endtask

  task automatic send_cfg(input logic [15:0] a, b, d, e, tx, ty, output int lat);
    int n;
    n = 0;
    while (!cfg_ready && n < 200) begin @(posedge clk); #1; n++; end
    check_value("cfg_ready_wait", cfg_ready, 1);
    k_a = a; k_b = b; k_d = d; k_e = e; k_tx = tx; k_ty = ty;
    cfg_a = a; cfg_b = b; cfg_d = d; cfg_e = e; cfg_tx = tx; cfg_ty = ty;
    cfg_valid = 1'b1;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    lat = 0;
    while (!cfg_ready && lat < 100) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic send_pt(input logic [15:0] x, y, input bit expect_res);
    int n;
    n = 0;
    while (!pt_ready && n < 200) begin @(posedge clk); #1; n++; end
    check_value("pt_ready_wait", pt_ready, 1);
    pt_x = x; pt_y = y; pt_valid = 1'b1;
    if (expect_res)
      exp_q.push_back({affine(k_a, k_b, x, y, k_tx), affine(k_d, k_e, x, y, k_ty)});
    @(posedge clk); #1;
    pt_valid = 1'b0;
  endtask

  task automatic wait_res(output int lat);
    lat = 0;
    while (!res_valid && lat < 500) begin @(posedge clk); #1; lat++; end
    check_value("res_valid_wait", res_valid, 1);
  endtask

  task automatic accept_res();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int lat, n, res_seen;
    rst_n = 1'b0; cfg_valid = 1'b0; pt_valid = 1'b0; res_ready = 1'b0;
    cfg_a = 0; cfg_b = 0; cfg_d = 0; cfg_e = 0; cfg_tx = 0; cfg_ty = 0;
    pt_x = 0; pt_y = 0;
    repeat (2) @(posedge clk);
    #1;
    check_value("rst_cfg_ready", cfg_ready, 0);
    check_value("rst_pt_ready", pt_ready, 0);
    check_value("rst_res_valid", res_valid, 0);
    check_value("rst_err", err_timeout, 0);
    check_value("rst_address", address, 0);
    check_value("rst_data_out", data_out, 0);
    check_value("rst_write_n", data_write_n, 2'b11);
    check_value("rst_read_n", data_read_n, 2'b11);
    rst_n = 1'b1;
    bus_log.delete();

    // identity-ish transform with offsets (5, -3)
    send_cfg(16'h0100, 16'h0000, 16'h0000, 16'h0100, 16'h0005, 16'hFFFD, lat);
    check_value("cfg_latency", lat, 12);
    exp_log.push_back(wr_ent(6'h08, 32'h0000_0100));
    exp_log.push_back(wr_ent(6'h0C, 32'h0000_0000));
    exp_log.push_back(wr_ent(6'h10, 32'h0000_0000));
    exp_log.push_back(wr_ent(6'h14, 32'h0000_0100));
    exp_log.push_back(wr_ent(6'h18, 32'h0000_0005));
    exp_log.push_back(wr_ent(6'h1C, 32'hFFFF_FFFD));
    compare_log("cfg_trace");

    // (10,20) -> (15,17); latency counted in edges after the accepting edge
    send_pt(16'd10, 16'd20, 1);
    wait_res(lat);
    check_value("res_latency", lat, W + 14);
    check_value("res_x_direct", res_x, 16'd15);
    check_value("res_y_direct", res_y, 16'd17);
    accept_res();
    exp_log.push_back(wr_ent(6'h20, 32'd10));
    exp_log.push_back(wr_ent(6'h24, 32'd20));
    exp_log.push_back(wr_ent(6'h00, 32'd1));
    exp_log.push_back(wr_ent(6'h00, 32'd0));
    exp_log.push_back(rd_ent(6'h04));
    exp_log.push_back(rd_ent(6'h28));
    exp_log.push_back(rd_ent(6'h2C));
    compare_log("pt_trace");

    // XOUT read stalled by three data_ready-low cycles
    stall_left = 3;
    send_pt(16'hFF9C, 16'd7, 1);
    wait_res(lat);
    accept_res();
    check_value("stall_read_cycles", xout_run_last, 4);
    check_value("stall_consumed", stall_left, 0);
    bus_log.delete();

    // STATUS never ready -> timeout after MP polls
    status_force0 = 1; status_reads = 0;
    send_pt(16'd1, 16'd2, 0);
    n = 0; res_seen = 0;
    while (!err_timeout && n < 400) begin
      @(posedge clk); #1; n++;
      if (res_valid) res_seen++;
    end
    check_value("timeout_err", err_timeout, 1);
    check_value("timeout_polls", status_reads, MP);
    check_value("timeout_no_res", res_seen, 0);
    check_value("timeout_idle_pt_ready", pt_ready, 1);
    exp_log.push_back(wr_ent(6'h20, 32'd1));
    exp_log.push_back(wr_ent(6'h24, 32'd2));
    exp_log.push_back(wr_ent(6'h00, 32'd1));
    exp_log.push_back(wr_ent(6'h00, 32'd0));
    for (int i = 0; i < MP; i++) exp_log.push_back(rd_ent(6'h04));
    repeat (3) @(posedge clk);
    #1;
    compare_log("timeout_trace");
    status_force0 = 0;
    send_pt(16'd3, 16'd4, 1);
    wait_res(lat);
    accept_res();
    check_value("err_sticky", err_timeout, 1);

    // cfg and pt offered together: cfg wins, point then uses the new set
    k_a = 16'h0200; k_b = 16'h0080; k_d = 16'hFF00; k_e = 16'h0100; k_tx = 16'h0000; k_ty = 16'h0010;
    cfg_a = k_a; cfg_b = k_b; cfg_d = k_d; cfg_e = k_e; cfg_tx = k_tx; cfg_ty = k_ty;
    cfg_valid = 1'b1; pt_x = 16'd8; pt_y = 16'd4; pt_valid = 1'b1;
    #1;
    check_value("both_pt_ready", pt_ready, 0);
    check_value("both_cfg_ready", cfg_ready, 1);
    exp_q.push_back({affine(k_a, k_b, 16'd8, 16'd4, k_tx), affine(k_d, k_e, 16'd8, 16'd4, k_ty)});
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    n = 0;
    while (!pt_ready && n < 100) begin @(posedge clk); #1; n++; end
    check_value("both_cfg_latency", n, 12);
    @(posedge clk); #1;
    pt_valid = 1'b0;
    wait_res(lat);
    bus_log.delete();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_value("hold_valid", res_valid, 1);
      check_value("hold_x", res_x, 16'd18);
      check_value("hold_y", res_y, 16'd12);
      check_value("hold_bus", {data_write_n, data_read_n}, 4'hF);
    end
    check_value("hold_no_txn", bus_log.size(), 0);
    accept_res();
    bus_log.delete();

    // reset while waiting on the peripheral
    send_pt(16'd5, 16'd5, 0);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_value("mid_rst_write_n", data_write_n, 2'b11);
    check_value("mid_rst_read_n", data_read_n, 2'b11);
    check_value("mid_rst_address", address, 0);
    check_value("mid_rst_res_valid", res_valid, 0);
    rst_n = 1'b1;
    bus_log.delete();
    pt_valid = 1'b1;
    #1;
    check_value("mid_rst_pt_refused", pt_ready, 0);
    repeat (3) @(posedge clk);
    #1;
    check_value("mid_rst_pt_still_refused", pt_ready, 0);
    check_value("mid_rst_no_bus", bus_log.size(), 0);
    pt_valid = 1'b0;

    check_value("sb_empty", exp_q.size(), 0);
    check_value("gap_violations", gap_viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
